// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the adder/subtractor, the result stage
// and the downstream flag/display logic.
interface alu_result_stage_if #(parameter int N = 4);
    logic         in_valid;
    logic         in_ready;
    logic         Op;
    logic         A_msb;
    logic         B_msb;
    logic [N-1:0] Sum;
    logic         Cout;
    logic [N-1:0] Sub;
    logic         Bout;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Result;
    logic         Flag_N;
    logic         Flag_Z;
    logic         Flag_C;
    logic         Flag_V;
    logic         Sticky_V;
    logic         clr_sticky;

    modport master (
        output in_valid, Op, A_msb, B_msb, Sum, Cout, Sub, Bout, out_ready, clr_sticky,
        input  in_ready, out_valid, Result, Flag_N, Flag_Z, Flag_C, Flag_V, Sticky_V
    );

    modport slave (
        input  in_valid, Op, A_msb, B_msb, Sum, Cout, Sub, Bout, out_ready, clr_sticky,
        output in_ready, out_valid, Result, Flag_N, Flag_Z, Flag_C, Flag_V, Sticky_V
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result stage: picks Sum/Sub, computes N/Z/C/V at push time and
// buffers {Result, flags} in a 2-entry FIFO; also tracks a sticky overflow bit.
module alu_result_stage #(
    parameter int N = 4
) (
    input logic               clk,
    input logic               rst,
    alu_result_stage_if.slave bus
);
    localparam int W = N + 4;

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   count;
    logic         push;
    logic         pop;
    logic [N-1:0] newRes;
    logic         newV;
    logic [W-1:0] newEntry;
    logic         sticky;

    // Entry layout is {Result, N, Z, C, V}; flags are frozen at push time.
    always_comb begin
        newRes   = bus.Op ? bus.Sub : bus.Sum;
        newV     = bus.Op ? ((bus.A_msb != bus.B_msb) && (newRes[N-1] != bus.A_msb))
                          : ((bus.A_msb == bus.B_msb) && (newRes[N-1] != bus.A_msb));
        newEntry = {newRes, newRes[N-1], (newRes == '0), (bus.Op ? bus.Bout : bus.Cout), newV};
    end

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // slot0 is always the head; slot1 only ever holds the second entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            if (pop && (count == 2'd2)) begin
                slot0 <= slot1;
            end else if (push && ((count == 2'd0) || pop)) begin
                slot0 <= newEntry;
            end else if (push) begin
                slot1 <= newEntry;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky <= 1'b0;
        end else if (bus.clr_sticky) begin
            sticky <= 1'b0;
        end else if (pop && slot0[0]) begin
            sticky <= 1'b1;
        end
    end

    assign bus.Result   = slot0[W-1:4];
    assign bus.Flag_N   = slot0[3];
    assign bus.Flag_Z   = slot0[2];
    assign bus.Flag_C   = slot0[1];
    assign bus.Flag_V   = slot0[0];
    assign bus.Sticky_V = sticky;
endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized self-checking bench for alu_result_stage (N=4) against a queue
// model that derives results and flags from integer operand arithmetic.
module tb_alu_result_stage;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    typedef struct {
        int res;
        bit n;
        bit z;
        bit c;
        bit v;
    } entry_t;

    entry_t modelQ[$];
    bit     modelSticky;

    alu_result_stage_if #(.N(N)) bus ();

    alu_result_stage #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic entry_t expectEntry(input bit op, input int a, input int b);
        entry_t e;
        int sa;
        int sb;
        int r;
        sa    = (a >= 8) ? a - 16 : a;
        sb    = (b >= 8) ? b - 16 : b;
        r     = op ? (sa - sb) : (sa + sb);
        e.res = op ? ((a - b + 16) % 16) : ((a + b) % 16);
        e.n   = (e.res >= 8);
        e.z   = (e.res == 0);
        e.c   = op ? (a < b) : ((a + b) > 15);
        e.v   = (r > 7) || (r < -8);
        return e;
    endfunction

    // Drives one cycle, checks pre-edge outputs, then advances the model across the edge.
    task automatic applyStimulus(input bit v, input bit op, input int a, input int b,
                                 input bit ordy, input bit clr);
        entry_t e;
        bit     doPush;
        bit     doPop;
        bit     popV;
        bus.in_valid   = v;
        bus.Op         = op;
        bus.A_msb      = (a >= 8);
        bus.B_msb      = (b >= 8);
        bus.Sum        = 4'((a + b) % 16);
        bus.Cout       = ((a + b) > 15);
        bus.Sub        = 4'((a - b + 16) % 16);
        bus.Bout       = (a < b);
        bus.out_ready  = ordy;
        bus.clr_sticky = clr;
        #1;
        checkOutput("out_valid", 32'(bus.out_valid), 32'(modelQ.size() != 0));
        checkOutput("in_ready", 32'(bus.in_ready), 32'(modelQ.size() < 2));
        checkOutput("sticky_v", 32'(bus.Sticky_V), 32'(modelSticky));
        if (modelQ.size() != 0) begin
            checkOutput("result", 32'(bus.Result), 32'(modelQ[0].res));
            checkOutput("flag_n", 32'(bus.Flag_N), 32'(modelQ[0].n));
            checkOutput("flag_z", 32'(bus.Flag_Z), 32'(modelQ[0].z));
            checkOutput("flag_c", 32'(bus.Flag_C), 32'(modelQ[0].c));
            checkOutput("flag_v", 32'(bus.Flag_V), 32'(modelQ[0].v));
        end
        e      = expectEntry(op, a, b);
        doPush = v && (modelQ.size() < 2);
        doPop  = ordy && (modelQ.size() != 0);
        popV   = 1'b0;
        @(posedge clk);
        if (doPop) begin
            popV = modelQ[0].v;
            void'(modelQ.pop_front());
        end
        if (doPush) modelQ.push_back(e);
        if (clr) modelSticky = 1'b0;
        else if (doPop && popV) modelSticky = 1'b1;
        #1;
    endtask

    task automatic checkIdleAfterReset();
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_result", 32'(bus.Result), 32'd0);
        checkOutput("rst_flags", 32'({bus.Flag_N, bus.Flag_Z, bus.Flag_C, bus.Flag_V}), 32'd0);
        checkOutput("rst_sticky", 32'(bus.Sticky_V), 32'd0);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        modelSticky = 1'b0;
        rst         = 1'b1;
        bus.in_valid   = 1'b0;
        bus.Op         = 1'b0;
        bus.A_msb      = 1'b0;
        bus.B_msb      = 1'b0;
        bus.Sum        = '0;
        bus.Cout       = 1'b0;
        bus.Sub        = '0;
        bus.Bout       = 1'b0;
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;
        @(negedge clk);
        checkIdleAfterReset();
        rst = 1'b0;

        // Directed: 7+3 overflows, then 5-5 and 3-5 via same-cycle push+pop at count 1.
        applyStimulus(1, 0, 7, 3, 0, 0);
        checkOutput("add73_result", 32'(bus.Result), 32'd10);
        checkOutput("add73_nzcv", 32'({bus.Flag_N, bus.Flag_Z, bus.Flag_C, bus.Flag_V}), 32'b1001);
        applyStimulus(1, 1, 5, 5, 1, 0);
        checkOutput("sub55_result", 32'(bus.Result), 32'd0);
        checkOutput("sub55_nzcv", 32'({bus.Flag_N, bus.Flag_Z, bus.Flag_C, bus.Flag_V}), 32'b0100);
        checkOutput("sticky_after_v_pop", 32'(bus.Sticky_V), 32'd1);
        applyStimulus(1, 1, 3, 5, 1, 0);
        checkOutput("sub35_result", 32'(bus.Result), 32'd14);
        checkOutput("sub35_nzcv", 32'({bus.Flag_N, bus.Flag_Z, bus.Flag_C, bus.Flag_V}), 32'b1010);
        checkOutput("count1_still_valid", 32'(bus.out_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("sticky_cleared", 32'(bus.Sticky_V), 32'd0);

        // Full FIFO with a stalled consumer; the third item is held until accepted.
        applyStimulus(1, 0, 1, 2, 0, 0);
        applyStimulus(1, 1, 9, 4, 0, 0);
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1, 0, 6, 6, 0, 0);
        checkOutput("held_head_result", 32'(bus.Result), 32'd3);
        applyStimulus(1, 0, 6, 6, 1, 0);
        applyStimulus(1, 0, 6, 6, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // clr_sticky wins over a same-cycle pop of an overflowing entry.
        applyStimulus(1, 0, 4, 4, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("clr_priority", 32'(bus.Sticky_V), 32'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset with two entries buffered.
        applyStimulus(1, 0, 7, 7, 0, 0);
        applyStimulus(1, 0, 5, 6, 0, 0);
        applyStimulus(1, 0, 2, 2, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checkIdleAfterReset();
        modelQ.delete();
        modelSticky = 1'b0;
        #1;
        rst = 1'b0;
        applyStimulus(1, 1, 2, 9, 1, 0);
        checkOutput("post_rst_push", 32'(bus.out_valid), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
